ram4_bank: RTL and testbench

- Four-word 16-bit register bank for the HACK memory hierarchy, built as the RAM4 storage stage.
- Its four word outputs (word_a..word_d) drive the data inputs of the downstream 4-way 16-bit selector; the address drives that selector's select input.
- Adds a valid/ready write port, a sequenced bulk-clear engine and a per-word written flag.
- Single clock domain.

---
 rtl/ram4_bank.sv | 119 +++++++++++
 tb/tb_ram4_bank.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ram4_bank.sv
// RAM4 storage stage: four WIDTH-bit words with a valid/ready write port,
// a four-cycle sequenced bulk clear and per-word written flags.
module ram4_bank #(
  parameter int               WIDTH     = 16,
  parameter logic [WIDTH-1:0] CLR_VALUE = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_valid,
  input  logic [1:0]       wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  output logic             wr_ready,
  input  logic             clr_req,
  output logic             clr_busy,
  input  logic [1:0]       rd_addr,
  output logic [WIDTH-1:0] rd_data,
  output logic [WIDTH-1:0] word_a,
  output logic [WIDTH-1:0] word_b,
  output logic [WIDTH-1:0] word_c,
  output logic [WIDTH-1:0] word_d,
  output logic [3:0]       written
);

  typedef enum logic [2:0] {
    IDLE,
    CLR0,
    CLR1,
    CLR2,
    CLR3
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic             clr_en;
  logic [1:0]       clr_idx;
  logic             wr_fire;
  logic [WIDTH-1:0] mem [4];
  logic [3:0]       flags;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Clear walks word 0..3, one per cycle; writes only land in IDLE.
  always_comb begin
    state_nxt = state;
    clr_busy  = 1'b0;
    clr_en    = 1'b0;
    clr_idx   = 2'd0;
    wr_ready  = 1'b0;
    unique case (state)
      IDLE: begin
        wr_ready = !clr_req;
        if (clr_req) begin
          state_nxt = CLR0;
        end
      end
      CLR0: begin
        clr_busy  = 1'b1;
        clr_en    = 1'b1;
        clr_idx   = 2'd0;
        state_nxt = CLR1;
      end
      CLR1: begin
        clr_busy  = 1'b1;
        clr_en    = 1'b1;
        clr_idx   = 2'd1;
        state_nxt = CLR2;
      end
      CLR2: begin
        clr_busy  = 1'b1;
        clr_en    = 1'b1;
        clr_idx   = 2'd2;
        state_nxt = CLR3;
      end
      CLR3: begin
        clr_busy  = 1'b1;
        clr_en    = 1'b1;
        clr_idx   = 2'd3;
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  assign wr_fire = wr_valid && wr_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) begin
        mem[i] <= CLR_VALUE;
      end
      flags <= 4'b0000;
    end else begin
      if (clr_en) begin
        mem[clr_idx]   <= CLR_VALUE;
        flags[clr_idx] <= 1'b0;
      end
      if (wr_fire) begin
        mem[wr_addr]   <= wr_data;
        flags[wr_addr] <= 1'b1;
      end
    end
  end

  assign rd_data = mem[rd_addr];
  assign word_a  = mem[0];
  assign word_b  = mem[1];
  assign word_c  = mem[2];
  assign word_d  = mem[3];
  assign written = flags;

endmodule

// File: tb/tb_ram4_bank.sv
// Directed and randomized checks of ram4_bank against a
// behavioural model of the bank contents and clear progress.
module tb_ram4_bank;

  logic        clk;
  logic        rst_n;
  logic        wr_valid;
  logic [1:0]  wr_addr;
  logic [15:0] wr_data;
  logic        wr_ready;
  logic        clr_req;
  logic        clr_busy;
  logic [1:0]  rd_addr;
  logic [15:0] rd_data;
  logic [15:0] word_a;
  logic [15:0] word_b;
  logic [15:0] word_c;
  logic [15:0] word_d;
  logic [3:0]  written;

  int checks = 0;
  int errors = 0;

  logic [15:0] m_mem [4];
  logic [3:0]  m_wr;
  int          m_left;

  ram4_bank #(.WIDTH(16), .CLR_VALUE(16'h0000)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .wr_valid (wr_valid),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .wr_ready (wr_ready),
    .clr_req  (clr_req),
    .clr_busy (clr_busy),
    .rd_addr  (rd_addr),
    .rd_data  (rd_data),
    .word_a   (word_a),
    .word_b   (word_b),
    .word_c   (word_c),
    .word_d   (word_d),
    .written  (written)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs,
                     input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic m_ready();
    return (m_left == 0) && !clr_req;
  endfunction

  task automatic check_all(input string tag);
    chk({tag, ":word_a"}, word_a, m_mem[0]);
    chk({tag, ":word_b"}, word_b, m_mem[1]);
    chk({tag, ":word_c"}, word_c, m_mem[2]);
    chk({tag, ":word_d"}, word_d, m_mem[3]);
    chk({tag, ":written"}, {12'd0, written}, {12'd0, m_wr});
    chk({tag, ":busy"}, {15'd0, clr_busy}, {15'd0, m_left > 0});
    chk({tag, ":ready"}, {15'd0, wr_ready}, {15'd0, m_ready()});
    chk({tag, ":rd_data"}, rd_data, m_mem[rd_addr]);
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) m_mem[i] = 16'h0000;
    m_wr   = 4'b0000;
    m_left = 0;
  endtask

  // Apply one rising edge to the model, then to the DUT, then compare.
  task automatic tick(input string tag);
    logic fire;
    int   idx;
    fire = wr_valid && m_ready();
    if (m_left > 0) begin
      idx = 4 - m_left;
      m_mem[idx] = 16'h0000;
      m_wr[idx]  = 1'b0;
      m_left--;
    end else if (clr_req) begin
      m_left = 4;
    end
    if (fire) begin
      m_mem[wr_addr] = wr_data;
      m_wr[wr_addr]  = 1'b1;
    end
    @(posedge clk);
    #1;
    check_all(tag);
  endtask

  task automatic do_write(input logic [1:0] a, input logic [15:0] d);
    wr_valid = 1'b1;
    wr_addr  = a;
    wr_data  = d;
    #1;
    chk("write_ready", {15'd0, wr_ready}, 16'd1);
    tick("write");
    wr_valid = 1'b0;
  endtask

  initial begin
    int stall;
    int busy_cnt;
    rst_n    = 1'b0;
    wr_valid = 1'b0;
    wr_addr  = 2'd0;
    wr_data  = 16'h0000;
    clr_req  = 1'b0;
    rd_addr  = 2'd0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;
    check_all("post_reset");

    do_write(2'd0, 16'h1234);
    do_write(2'd1, 16'hBEEF);
    do_write(2'd2, 16'h7FFF);
    do_write(2'd3, 16'h8000);
    chk("wr_a", word_a, 16'h1234);
    chk("wr_b", word_b, 16'hBEEF);
    chk("wr_c", word_c, 16'h7FFF);
    chk("wr_d", word_d, 16'h8000);
    chk("wr_flags", {12'd0, written}, 16'h000F);
    for (int i = 0; i < 4; i++) begin
      rd_addr = 2'(i);
      #1;
      chk("readback", rd_data, m_mem[i]);
    end

    // Async reset mid-cycle with every word written.
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all("async_reset");
    chk("rst_flags", {12'd0, written}, 16'h0000);
    #1;
    rst_n = 1'b1;

    do_write(2'd0, 16'h1234);
    do_write(2'd1, 16'hBEEF);
    do_write(2'd2, 16'h7FFF);
    do_write(2'd3, 16'h8000);

    wr_valid = 1'b1;
    wr_addr  = 2'd2;
    wr_data  = 16'hAAAA;
    rd_addr  = 2'd2;
    #1;
    chk("same_cycle_old", rd_data, 16'h7FFF);
    tick("same_cycle");
    wr_valid = 1'b0;
    #1;
    chk("same_cycle_new", rd_data, 16'hAAAA);

    // Bulk clear with a redundant request while busy.
    clr_req = 1'b1;
    #1;
    chk("clr_start_ready", {15'd0, wr_ready}, 16'd0);
    tick("clr_start");
    clr_req  = 1'b0;
    busy_cnt = 0;
    for (int c = 0; c < 6; c++) begin
      if (clr_busy) busy_cnt++;
      clr_req = (c == 1);
      #1;
      tick("clr_walk");
      if (c == 0) chk("clr_w0", {12'd0, written}, 16'h000E);
      if (c == 1) chk("clr_w1", {12'd0, written}, 16'h000C);
      if (c == 2) chk("clr_w2", {12'd0, written}, 16'h0008);
      if (c == 3) chk("clr_w3", {12'd0, written}, 16'h0000);
      clr_req = 1'b0;
    end
    chk("clr_busy_cycles", 16'(busy_cnt), 16'd4);

    // Write held through a clear is stalled, then lands.
    wr_valid = 1'b1;
    wr_addr  = 2'd1;
    wr_data  = 16'h5555;
    clr_req  = 1'b1;
    stall    = 0;
    for (int c = 0; c < 20 && wr_valid; c++) begin
      #1;
      if (!wr_ready) stall++;
      if (wr_ready) begin
        tick("stall_land");
        wr_valid = 1'b0;
      end else begin
        tick("stall_wait");
      end
      clr_req = 1'b0;
    end
    chk("stall_done", {15'd0, wr_valid}, 16'd0);
    chk("stall_cycles", 16'(stall), 16'd5);
    chk("stall_word_b", word_b, 16'h5555);
    chk("stall_flag", {15'd0, written[1]}, 16'd1);

    // Reset while the clear engine is in its second step.
    do_write(2'd3, 16'h0F0F);
    clr_req = 1'b1;
    tick("rclr_req");
    clr_req = 1'b0;
    tick("rclr_c0");
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all("reset_mid_clear");
    #2;
    rst_n = 1'b1;
    tick("after_rst1");
    tick("after_rst2");

    for (int n = 0; n < 400; n++) begin
      wr_valid = ($urandom_range(0, 2) != 0);
      wr_addr  = 2'($urandom_range(0, 3));
      wr_data  = 16'($urandom);
      clr_req  = ($urandom_range(0, 15) == 0);
      rd_addr  = 2'($urandom_range(0, 3));
      #1;
      chk("rand_ready", {15'd0, wr_ready}, {15'd0, m_ready()});
      chk("rand_rd", rd_data, m_mem[rd_addr]);
      tick("rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
